// File: rtl/level_meter_scheduler_if.sv
// Stereo PCM input, converter handshake and display outputs
// of the level meter scheduler, bundled for port connection.
interface level_meter_scheduler_if;
    logic        i_valid;
    logic        i_ready;
    logic [15:0] pcm_left;
    logic [15:0] pcm_right;

    logic        conv_valid;
    logic        conv_ready;
    logic [14:0] conv_pcm;
    logic        conv_o_valid;
    logic        conv_o_ready;
    logic [4:0]  conv_position;

    logic [4:0]  level_left;
    logic [4:0]  level_right;
    logic [4:0]  peak_left;
    logic [4:0]  peak_right;
    logic        update;

    modport slave (
        input  i_valid, pcm_left, pcm_right,
        input  conv_ready, conv_o_valid, conv_position,
        output i_ready,
        output conv_valid, conv_pcm, conv_o_ready,
        output level_left, level_right, peak_left, peak_right,
        output update
    );

    modport master (
        output i_valid, pcm_left, pcm_right,
        output conv_ready, conv_o_valid, conv_position,
        input  i_ready,
        input  conv_valid, conv_pcm, conv_o_ready,
        input  level_left, level_right, peak_left, peak_right,
        input  update
    );
endinterface

// File: rtl/level_meter_scheduler.sv
// Stereo peak accumulator that time-shares one PCM-to-position
// converter per window and publishes level/peak-hold markers.
module level_meter_scheduler #(
    parameter int unsigned WINDOW       = 1024,
    parameter int unsigned HOLD_UPDATES = 16
) (
    input logic Clock,
    input logic Reset,
    level_meter_scheduler_if.slave bus
);

    localparam logic [15:0] LAST = 16'(WINDOW - 1);
    localparam logic [7:0]  HOLD = 8'(HOLD_UPDATES);

    typedef enum logic [2:0] {
        IDLE, SEND_L, WAIT_L, SEND_R, WAIT_R, PUBLISH
    } state_t;

    typedef struct packed {
        logic [4:0] peak;
        logic [7:0] hold;
    } hold_t;

    state_t      state, state_n;
    logic [15:0] count, count_n;
    logic [14:0] acc_l, acc_r;
    logic [14:0] snap_l, snap_r;
    logic [14:0] mag_l, mag_r;
    logic [14:0] max_l, max_r;
    logic        pending, pending_n, pend_clr;
    logic        ready_q, ready_n;
    logic        accept, at_last, snap_take;
    logic [4:0]  pos_l, pos_r;
    logic [4:0]  level_l, level_r;
    hold_t       hold_l, hold_r;
    hold_t       hold_l_n, hold_r_n;
    logic        update_q;
    logic        conv_valid, conv_o_ready, publish;
    logic [14:0] conv_pcm;

    function automatic logic [14:0] magnitude(input logic [15:0] x);
        logic [15:0] neg;
        neg = ~x + 16'd1;
        if (!x[15])
            return x[14:0];
        // only -32768 negates to a value with bit 15 still set
        if (neg[15])
            return 15'h7fff;
        return neg[14:0];
    endfunction

    function automatic hold_t hold_step(
        input logic [4:0] pos,
        input hold_t      cur
    );
        hold_t nxt;
        nxt = cur;
        if (pos >= cur.peak) begin
            nxt.peak = pos;
            nxt.hold = HOLD;
        end else if (cur.hold != 8'd0) begin
            nxt.hold = cur.hold - 8'd1;
        end else begin
            nxt.peak = (pos > cur.peak - 5'd1) ? pos : cur.peak - 5'd1;
        end
        return nxt;
    endfunction

    assign mag_l     = magnitude(bus.pcm_left);
    assign mag_r     = magnitude(bus.pcm_right);
    assign max_l     = (mag_l > acc_l) ? mag_l : acc_l;
    assign max_r     = (mag_r > acc_r) ? mag_r : acc_r;
    assign accept    = bus.i_valid & ready_q;
    assign at_last   = (count == LAST);
    assign snap_take = accept & at_last;
    assign hold_l_n  = hold_step(pos_l, hold_l);
    assign hold_r_n  = hold_step(pos_r, hold_r);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n      = state;
        conv_valid   = 1'b0;
        conv_pcm     = 15'd0;
        conv_o_ready = 1'b0;
        pend_clr     = 1'b0;
        publish      = 1'b0;
        unique case (state)
            IDLE: begin
                if (pending) begin
                    pend_clr = 1'b1;
                    state_n  = SEND_L;
                end
            end
            SEND_L: begin
                conv_valid = 1'b1;
                conv_pcm   = snap_l;
                if (bus.conv_ready)
                    state_n = WAIT_L;
            end
            WAIT_L: begin
                conv_o_ready = 1'b1;
                if (bus.conv_o_valid)
                    state_n = SEND_R;
            end
            SEND_R: begin
                conv_valid = 1'b1;
                conv_pcm   = snap_r;
                if (bus.conv_ready)
                    state_n = WAIT_R;
            end
            WAIT_R: begin
                conv_o_ready = 1'b1;
                if (bus.conv_o_valid)
                    state_n = PUBLISH;
            end
            PUBLISH: begin
                publish = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // i_ready is registered from next-cycle values so the last pair
    // of a window is never offered while the snapshot is still busy
    always_comb begin
        count_n = count;
        if (accept)
            count_n = at_last ? 16'd0 : count + 16'd1;
        pending_n = snap_take | (pending & ~pend_clr);
        ready_n   = !((count_n == LAST) &&
                      (pending_n || (state_n != IDLE)));
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count   <= 16'd0;
            pending <= 1'b0;
            ready_q <= 1'b0;
            acc_l   <= 15'd0;
            acc_r   <= 15'd0;
            snap_l  <= 15'd0;
            snap_r  <= 15'd0;
        end else begin
            count   <= count_n;
            pending <= pending_n;
            ready_q <= ready_n;
            if (accept) begin
                acc_l <= at_last ? 15'd0 : max_l;
                acc_r <= at_last ? 15'd0 : max_r;
            end
            if (snap_take) begin
                snap_l <= max_l;
                snap_r <= max_r;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pos_l <= 5'd0;
            pos_r <= 5'd0;
        end else begin
            if (state == WAIT_L && bus.conv_o_valid)
                pos_l <= bus.conv_position;
            if (state == WAIT_R && bus.conv_o_valid)
                pos_r <= bus.conv_position;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            level_l  <= 5'd0;
            level_r  <= 5'd0;
            hold_l   <= '0;
            hold_r   <= '0;
            update_q <= 1'b0;
        end else begin
            update_q <= publish;
            if (publish) begin
                level_l <= pos_l;
                level_r <= pos_r;
                hold_l  <= hold_l_n;
                hold_r  <= hold_r_n;
            end
        end
    end

    assign bus.i_ready      = ready_q;
    assign bus.conv_valid   = conv_valid;
    assign bus.conv_pcm     = conv_pcm;
    assign bus.conv_o_ready = conv_o_ready;
    assign bus.level_left   = level_l;
    assign bus.level_right  = level_r;
    assign bus.peak_left    = hold_l.peak;
    assign bus.peak_right   = hold_r.peak;
    assign bus.update       = update_q;

endmodule

// File: tb/tb_level_meter_scheduler.sv
// Scoreboard bench for level_meter_scheduler: window/peak-hold model,
// converter stub with random stalls/delays, and an update monitor.
module tb_level_meter_scheduler;
    localparam int W    = 4;
    localparam int HOLD = 2;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    level_meter_scheduler_if bus();

    level_meter_scheduler #(
        .WINDOW(W),
        .HOLD_UPDATES(HOLD)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus(bus)
    );

    typedef struct packed {
        logic [4:0] ll;
        logic [4:0] lr;
        logic [4:0] pl;
        logic [4:0] pr;
    } pub_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_upd = 0;
    pub_t exp_q[$];
    int   conv_q[$];
    int   win_l[$];
    int   win_r[$];
    int   pk[2];
    int   hc[2];
    pub_t last_pub;
    pub_t mon_e;

    int         stall_force = -1;
    int         delay_force[2];
    int         phase = 0;
    int         stall_left = 0;
    int         dly = 0;
    int         st_ch = 0;
    int         st_next = 0;
    logic [4:0] stub_pos = 5'd0;

    logic [15:0] bl[4];
    logic [15:0] br[4];

    task automatic check(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, act, want, $time);
        end
    endtask

    function automatic int mag(input logic [15:0] x);
        int v;
        v = int'($signed(x));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    function automatic int hold_update(input int c, input int pos);
        if (pos >= pk[c]) begin
            pk[c] = pos;
            hc[c] = HOLD;
        end else if (hc[c] > 0) begin
            hc[c] = hc[c] - 1;
        end else begin
            pk[c] = (pos > pk[c] - 1) ? pos : pk[c] - 1;
        end
        return pk[c];
    endfunction

    function automatic pub_t cur_pub();
        pub_t p;
        p.ll = bus.level_left;
        p.lr = bus.level_right;
        p.pl = bus.peak_left;
        p.pr = bus.peak_right;
        return p;
    endfunction

    function automatic logic [15:0] rnd_sample();
        int unsigned s;
        s = $urandom_range(0, 9);
        if (s == 0) return 16'h8000;
        if (s == 1) return 16'h7fff;
        if (s == 2) return 16'h0000;
        return 16'($urandom);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        conv_q.delete();
        win_l.delete();
        win_r.delete();
        pk[0] = 0; pk[1] = 0;
        hc[0] = 0; hc[1] = 0;
        last_pub = '0;
        stall_force = -1;
        delay_force[0] = -1;
        delay_force[1] = -1;
    endtask

    // window maxima become the converter inputs; position is mag/1024
    task automatic model_accept(input logic [15:0] l, input logic [15:0] r);
        int   ml;
        int   mr;
        pub_t p;
        win_l.push_back(mag(l));
        win_r.push_back(mag(r));
        if (win_l.size() == W) begin
            ml = 0;
            mr = 0;
            foreach (win_l[i]) begin
                if (win_l[i] > ml) ml = win_l[i];
                if (win_r[i] > mr) mr = win_r[i];
            end
            win_l.delete();
            win_r.delete();
            conv_q.push_back(ml);
            conv_q.push_back(mr);
            p.ll = 5'(ml / 1024);
            p.lr = 5'(mr / 1024);
            p.pl = 5'(hold_update(0, ml / 1024));
            p.pr = 5'(hold_update(1, mr / 1024));
            exp_q.push_back(p);
        end
    endtask

    task automatic send_pair(input logic [15:0] l, input logic [15:0] r,
                             input int gap, output int waited);
        bus.i_valid = 1'b0;
        repeat (gap) @(negedge Clock);
        bus.pcm_left  = l;
        bus.pcm_right = r;
        bus.i_valid   = 1'b1;
        waited = 0;
        while (bus.i_ready !== 1'b1 && waited < 500) begin
            @(negedge Clock);
            waited++;
        end
        if (waited >= 500) begin
            n_cmp++;
            n_bad++;
            $display("FAIL i_ready_timeout: got 0, expected 1 within 500 cycles");
        end else begin
            @(posedge Clock);
            model_accept(l, r);
        end
        @(negedge Clock);
        bus.i_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || phase != 0) && n < 3000) begin
            @(negedge Clock);
            n++;
        end
        if (n >= 3000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending updates, expected 0",
                     exp_q.size());
        end
        repeat (2) @(negedge Clock);
    endtask

    task automatic assert_reset();
        #1 Reset = 1'b1;
        model_reset();
        #1;
        check("rst_i_ready", int'(bus.i_ready), 0);
        check("rst_conv_valid", int'(bus.conv_valid), 0);
        check("rst_conv_o_ready", int'(bus.conv_o_ready), 0);
        check("rst_conv_pcm", int'(bus.conv_pcm), 0);
        check("rst_update", int'(bus.update), 0);
        check("rst_outputs", int'(cur_pub()), 0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        check("i_ready_after_reset", int'(bus.i_ready), 1);
    endtask

    task automatic stub_accept();
        int e;
        bus.conv_ready = 1'b1;
        if (conv_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL conv_unexpected: got pcm %0d, expected no request",
                     bus.conv_pcm);
        end else begin
            e = conv_q.pop_front();
            check("conv_pcm", int'(bus.conv_pcm), e);
        end
        stub_pos = bus.conv_pcm[14:10];
        st_ch    = st_next;
        st_next  = 1 - st_next;
        dly = (delay_force[st_ch] >= 0) ? delay_force[st_ch]
                                        : int'($urandom_range(0, 6));
        delay_force[st_ch] = -1;
        phase = 2;
    endtask

    // converter stub: pos = pcm[14:10], random input stall and output delay
    initial begin
        bus.conv_ready    = 1'b0;
        bus.conv_o_valid  = 1'b0;
        bus.conv_position = 5'd0;
        forever begin
            @(negedge Clock);
            if (Reset) begin
                bus.conv_ready   = 1'b0;
                bus.conv_o_valid = 1'b0;
                phase   = 0;
                st_next = 0;
            end else begin
                if (phase == 4) begin
                    bus.conv_o_valid = 1'b0;
                    phase = 0;
                end
                case (phase)
                    0: begin
                        if (bus.conv_valid) begin
                            stall_left = (stall_force >= 0) ? stall_force
                                         : int'($urandom_range(0, 4));
                            stall_force = -1;
                            if (stall_left == 0) stub_accept();
                            else begin
                                bus.conv_ready = 1'b0;
                                phase = 1;
                            end
                        end
                    end
                    1: begin
                        check("conv_valid_held", int'(bus.conv_valid), 1);
                        if (conv_q.size() > 0)
                            check("conv_pcm_held", int'(bus.conv_pcm), conv_q[0]);
                        stall_left--;
                        if (stall_left == 0) stub_accept();
                    end
                    2: begin
                        bus.conv_ready = 1'b0;
                        check("conv_o_ready_wait", int'(bus.conv_o_ready), 1);
                        if (dly == 0) begin
                            bus.conv_o_valid  = 1'b1;
                            bus.conv_position = stub_pos;
                            phase = 4;
                        end else begin
                            dly--;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // monitor: every update pops one expected publication
    initial begin
        forever begin
            @(negedge Clock);
            if (!Reset) begin
                if (bus.update === 1'b1) begin
                    n_upd++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_update: got pulse, expected none at %0t",
                                 $time);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("level_left", int'(bus.level_left), int'(mon_e.ll));
                        check("level_right", int'(bus.level_right), int'(mon_e.lr));
                        check("peak_left", int'(bus.peak_left), int'(mon_e.pl));
                        check("peak_right", int'(bus.peak_right), int'(mon_e.pr));
                        last_pub = mon_e;
                    end
                end else begin
                    check("outputs_steady", int'(cur_pub()), int'(last_pub));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int u0;
        int n;
        bus.i_valid   = 1'b0;
        bus.pcm_left  = 16'd0;
        bus.pcm_right = 16'd0;
        bl[0] = 16'h0100; bl[1] = 16'h1000; bl[2] = 16'hf800; bl[3] = 16'h0000;
        br[0] = 16'hfe00; br[1] = 16'h0005; br[2] = 16'h0000; br[3] = 16'h0001;

        assert_reset();

        for (int i = 0; i < W; i++) send_pair(bl[i], br[i], 0, w);
        drain();
        check("basic_level_left", int'(bus.level_left), 4);
        check("basic_level_right", int'(bus.level_right), 0);
        check("basic_peak_left", int'(bus.peak_left), 4);
        check("basic_peak_right", int'(bus.peak_right), 0);

        for (int i = 0; i < W; i++) send_pair(16'h8000, 16'h7fff, i % 2, w);
        drain();
        check("sat_level_left", int'(bus.level_left), 31);
        check("sat_level_right", int'(bus.level_right), 31);

        @(negedge Clock);
        assert_reset();
        for (int k = 0; k < 14; k++) begin
            for (int j = 0; j < W; j++)
                send_pair((k == 0) ? 16'h5000 : 16'h2800, 16'h0000, 0, w);
            drain();
            check("hold_level_left", int'(bus.level_left), (k == 0) ? 20 : 10);
            check("hold_peak_left", int'(bus.peak_left),
                  (k < 3) ? 20 : ((22 - k > 10) ? 22 - k : 10));
        end

        stall_force = 40;
        for (int i = 0; i < 2 * W; i++) begin
            send_pair(rnd_sample(), rnd_sample(), 0, w);
            if (i == 2 * W - 1)
                check("bp_i_ready_low", (w > 30) ? 1 : 0, 1);
        end
        drain();

        delay_force[0] = 10;
        for (int i = 0; i < W; i++) send_pair(rnd_sample(), rnd_sample(), 0, w);
        drain();

        delay_force[1] = 20;
        for (int i = 0; i < W; i++) send_pair(rnd_sample(), rnd_sample(), 0, w);
        n = 0;
        while (!(phase == 2 && st_ch == 1) && n < 300) begin
            @(negedge Clock);
            n++;
        end
        check("reached_wait_r", (n < 300) ? 1 : 0, 1);
        assert_reset();
        u0 = n_upd;
        for (int i = 0; i < W; i++) send_pair(rnd_sample(), rnd_sample(), 0, w);
        drain();
        check("one_update_after_reset", n_upd - u0, 1);

        for (int k = 0; k < 25; k++) begin
            for (int j = 0; j < W; j++)
                send_pair(rnd_sample(), rnd_sample(),
                          int'($urandom_range(0, 2)), w);
        end
        drain();
        check("conv_queue_empty", conv_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
